// File: rtl/mod7_aciona_rega.sv
// Irrigation actuator sequencer: turns a level request (vs = sprinkler,
// bs = drip) into open valve -> settle -> pump (min run) -> drain -> close.
// Guards against conflicting requests and a low water tank.
module mod7_aciona_rega #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned MIN_RUN_CYC = 8,
    parameter int unsigned DRAIN_CYC   = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    input  logic bs,
    input  logic cx_baixa,
    output logic valv_asp,
    output logic valv_got,
    output logic bomba,
    output logic busy,
    output logic err
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(MIN_RUN_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt_c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic             tipo;
    logic             tipo_nxt_c;
    logic             err_pend;
    logic             err_pend_nxt_c;

    logic             conflict_c;
    logic             req_sel_c;
    logic             req_oth_c;
    logic             valve_on_c;

    // Request decode relative to the latched irrigation type
    always_comb begin
        conflict_c = vs & bs;
        req_sel_c  = tipo ? vs : bs;
        req_oth_c  = tipo ? bs : vs;
    end

    // Next-state, counter, type latch and pending-error logic
    always_comb begin
        state_nxt_c    = state;
        cnt_nxt_c      = cnt + CNT_ONE;
        tipo_nxt_c     = tipo;
        err_pend_nxt_c = err_pend;

        unique case (state)
            S_IDLE: begin
                cnt_nxt_c = '0;
                if (conflict_c) begin
                    state_nxt_c = S_ERR;
                end else if (cx_baixa) begin
                    state_nxt_c = S_IDLE;
                end else if (vs) begin
                    state_nxt_c = S_OPEN;
                    tipo_nxt_c  = 1'b1;
                end else if (bs) begin
                    state_nxt_c = S_OPEN;
                    tipo_nxt_c  = 1'b0;
                end
            end

            S_OPEN: begin
                if (conflict_c) begin
                    state_nxt_c    = S_DRAIN;
                    err_pend_nxt_c = 1'b1;
                    cnt_nxt_c      = '0;
                end else if (cx_baixa) begin
                    state_nxt_c = S_DRAIN;
                    cnt_nxt_c   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt_c = S_RUN;
                    cnt_nxt_c   = '0;
                end
            end

            S_RUN: begin
                // Counter saturates once the minimum run time is reached
                if (cnt == RUN_LAST) begin
                    cnt_nxt_c = cnt;
                end
                if (conflict_c) begin
                    state_nxt_c    = S_DRAIN;
                    err_pend_nxt_c = 1'b1;
                    cnt_nxt_c      = '0;
                end else if (cx_baixa) begin
                    state_nxt_c = S_DRAIN;
                    cnt_nxt_c   = '0;
                end else if (!req_sel_c && req_oth_c) begin
                    state_nxt_c = S_DRAIN;
                    cnt_nxt_c   = '0;
                end else if (!req_sel_c && (cnt == RUN_LAST)) begin
                    state_nxt_c = S_DRAIN;
                    cnt_nxt_c   = '0;
                end
            end

            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt_c = err_pend ? S_ERR : S_IDLE;
                    cnt_nxt_c   = '0;
                end
            end

            S_ERR: begin
                cnt_nxt_c      = '0;
                err_pend_nxt_c = 1'b0;
                if (!vs && !bs) begin
                    state_nxt_c = S_IDLE;
                end
            end

            default: begin
                state_nxt_c    = S_IDLE;
                cnt_nxt_c      = '0;
                err_pend_nxt_c = 1'b0;
            end
        endcase
    end

    // Valve is open in every active phase of the sequence
    always_comb begin
        valve_on_c = (state_nxt_c == S_OPEN) || (state_nxt_c == S_RUN) ||
                     (state_nxt_c == S_DRAIN);
    end

    // State register with outputs decoded from the next state (registered Moore)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tipo     <= 1'b0;
            err_pend <= 1'b0;
            valv_asp <= 1'b0;
            valv_got <= 1'b0;
            bomba    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt_c;
            cnt      <= cnt_nxt_c;
            tipo     <= tipo_nxt_c;
            err_pend <= err_pend_nxt_c;
            valv_asp <= valve_on_c & tipo_nxt_c;
            valv_got <= valve_on_c & ~tipo_nxt_c;
            bomba    <= (state_nxt_c == S_RUN);
            busy     <= valve_on_c;
            err      <= (state_nxt_c == S_ERR);
        end
    end

endmodule

// File: tb/tb_mod7_aciona_rega.sv
// Directed bench for mod7_aciona_rega: a per-cycle vector table plus
// hand-written sequences for reset-in-run and conflict/abort corners.
module tb_mod7_aciona_rega;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs = 1'b0;
    logic bs = 1'b0;
    logic cx_baixa = 1'b0;
    logic valv_asp;
    logic valv_got;
    logic bomba;
    logic busy;
    logic err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Inputs {rst,vs,bs,cx} and expected outputs {valv_asp,valv_got,bomba,busy,err}
    typedef struct {
        logic [3:0] in;
        logic [4:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    mod7_aciona_rega #(
        .SETTLE_CYC (4),
        .MIN_RUN_CYC(8),
        .DRAIN_CYC  (4),
        .CNT_W      (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vs      (vs),
        .bs      (bs),
        .cx_baixa(cx_baixa),
        .valv_asp(valv_asp),
        .valv_got(valv_got),
        .bomba   (bomba),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic add_n(input int n, input logic [3:0] in, input logic [4:0] exp,
                         input string tag);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, sample #1 after the edge and compare
    task automatic step(input logic [3:0] in, input logic [4:0] exp, input string tag);
        logic [4:0] act;
        {rst, vs, bs, cx_baixa} = in;
        @(posedge clk);
        #1;
        cyc++;
        act = {valv_asp, valv_got, bomba, busy, err};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d in(rst,vs,bs,cx)=%b got(asp,got,bomba,busy,err)=%b want=%b",
                     tag, cyc, in, act, exp);
        end
    endtask

    initial begin
        // Reset
        add_n(2,  4'b1000, 5'b00000, "reset");
        // Sprinkler held 20 cycles: settle 4, run 16, drain 4, close
        add_n(4,  4'b0100, 5'b10010, "vs_open");
        add_n(16, 4'b0100, 5'b10110, "vs_run");
        add_n(4,  4'b0000, 5'b10010, "vs_drain");
        add_n(2,  4'b0000, 5'b00000, "vs_closed");
        // Drip pulsed 2 cycles: full min run of 8 still happens
        add_n(2,  4'b0010, 5'b01010, "bs_open_req");
        add_n(2,  4'b0000, 5'b01010, "bs_open_noreq");
        add_n(8,  4'b0000, 5'b01110, "bs_minrun");
        add_n(4,  4'b0000, 5'b01010, "bs_drain");
        add_n(1,  4'b0000, 5'b00000, "bs_closed");
        // Conflict in IDLE
        add_n(2,  4'b0110, 5'b00001, "idle_conflict");
        add_n(1,  4'b0000, 5'b00000, "conflict_clear");
        // Drip held, tank low in 7th cycle aborts the run
        add_n(4,  4'b0010, 5'b01010, "cx_open");
        add_n(2,  4'b0010, 5'b01110, "cx_run");
        add_n(4,  4'b0011, 5'b01010, "cx_drain");
        add_n(3,  4'b0011, 5'b00000, "cx_blocks_bs");
        add_n(2,  4'b0101, 5'b00000, "cx_blocks_vs");
        add_n(1,  4'b0000, 5'b00000, "cx_idle");

        foreach (vecs[i]) step(vecs[i].in, vecs[i].exp, vecs[i].tag);

        // Reset in the middle of RUN: everything off, no drain
        repeat (4) step(4'b0100, 5'b10010, "rr_open");
        repeat (2) step(4'b0100, 5'b10110, "rr_run");
        step(4'b1100, 5'b00000, "rr_reset");
        step(4'b0000, 5'b00000, "rr_after");

        // Conflict in RUN: pump off at once, 4 drain cycles, then err until released
        repeat (4) step(4'b0100, 5'b10010, "cr_open");
        repeat (2) step(4'b0100, 5'b10110, "cr_run");
        step(4'b0110, 5'b10010, "cr_conflict");
        repeat (3) step(4'b0100, 5'b10010, "cr_drain");
        repeat (2) step(4'b0100, 5'b00001, "cr_err_hold");
        step(4'b0000, 5'b00000, "cr_release");

        // Conflict while settling: drain then err
        step(4'b0010, 5'b01010, "co_open");
        repeat (4) step(4'b0110, 5'b01010, "co_drain");
        repeat (2) step(4'b0110, 5'b00001, "co_err");
        step(4'b0000, 5'b00000, "co_release");

        // Tank low while settling: drain without error
        step(4'b0100, 5'b10010, "xo_open");
        repeat (4) step(4'b0101, 5'b10010, "xo_drain");
        step(4'b0000, 5'b00000, "xo_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
